// File: rtl/ddr_video_pkg.sv
// Shared DDR video definitions: write-packer FSM states, word geometry and MIG command codes.
package ddr_video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE,
    DONE
  } wp_state_e;

  localparam int unsigned PIXELS_PER_WORD = 5;
  localparam int unsigned WORD_ADDR_STEP  = 8;
  localparam logic [2:0]  APP_CMD_WRITE   = 3'b000;

  // Byte mask for a word carrying 'pixels' RGB pixels: every byte past the last pixel is masked.
  function automatic logic [15:0] tail_mask(input int unsigned pixels);
    logic [15:0] m;
    m = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      m[b] = (b >= 3 * pixels);
    end
    return m;
  endfunction

endpackage

// File: rtl/pixel_slot_shifter.sv
// Five-slot pixel capture register; each captured pixel lands in the next free 24-bit slot.
module pixel_slot_shifter
  import ddr_video_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         capture,
  input  logic [23:0]  din,
  output logic [119:0] slots,
  output logic [2:0]   slot_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots    <= '0;
      slot_idx <= '0;
    end else if (clear) begin
      slots    <= '0;
      slot_idx <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < PIXELS_PER_WORD; k++) begin
        if (slot_idx == 3'(k)) begin
          slots[24*k +: 24] <= din;
        end
      end
      slot_idx <= slot_idx + 3'd1;
    end
  end

endmodule

// File: rtl/write_word_packer.sv
// Packs 24-bit FIFO pixels five per 128-bit MIG write word and issues them to sequential DDR addresses.
// Define WRITE_PACKER_MASK_EN to mask the pad byte and unused pixel bytes of a partial final word.
module write_word_packer
  import ddr_video_pkg::*;
#(
  parameter int unsigned           FRAME_PIXELS = 786432,
  parameter int unsigned           NUM_FRAMES   = 1,
  parameter int unsigned           ADDR_WIDTH   = 27,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                  clk,
  input  logic                  cpu_resetn,
  input  logic                  init_calib_complete,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [23:0]           fifo_dout,
  input  logic                  fifo_valid,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [127:0]          app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic                  end_of_write
);

  localparam int unsigned WORDS_PER_FRAME = (FRAME_PIXELS + PIXELS_PER_WORD - 1) / PIXELS_PER_WORD;
  localparam int unsigned TAIL_PIXELS     = FRAME_PIXELS % PIXELS_PER_WORD;
  localparam int unsigned WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int unsigned FCNT_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  wp_state_e         state;
  logic [WCNT_W-1:0] word_cnt;
  logic [FCNT_W-1:0] frame_cnt;
  logic [2:0]        req_cnt;
  logic [2:0]        slot_idx;
  logic [2:0]        needed;
  logic [119:0]      slots;
  logic              last_word;
  logic              last_frame;
  logic              capture;
  logic              word_full;
  logic              accept;

  assign last_word  = (word_cnt == WCNT_W'(WORDS_PER_FRAME - 1));
  assign last_frame = (frame_cnt == FCNT_W'(NUM_FRAMES - 1));
  assign needed     = (last_word && TAIL_PIXELS != 0) ? 3'(TAIL_PIXELS) : 3'(PIXELS_PER_WORD);

  // (requested - received) < (needed - received) reduces to requested < needed.
  assign fifo_rd_en = (state == FILL) && !fifo_empty && (req_cnt < needed);
  assign capture    = (state == FILL) && fifo_valid;
  assign word_full  = capture && (slot_idx == needed - 3'd1);
  assign accept     = (state == ISSUE) && (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);

  assign app_cmd      = APP_CMD_WRITE;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = {8'h00, slots};

  pixel_slot_shifter u_slots (
    .clk      (clk),
    .rst_n    (cpu_resetn),
    .clear    (accept),
    .capture  (capture),
    .din      (fifo_dout),
    .slots    (slots),
    .slot_idx (slot_idx)
  );

`ifdef WRITE_PACKER_MASK_EN
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      app_wdf_mask <= '0;
    end else if (word_full) begin
      app_wdf_mask <= (last_word && TAIL_PIXELS != 0) ? tail_mask(TAIL_PIXELS)
                                                      : tail_mask(PIXELS_PER_WORD);
    end
  end
`else
  assign app_wdf_mask = '0;
`endif

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state        <= IDLE;
      app_addr     <= BASE_ADDR;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      end_of_write <= 1'b0;
      word_cnt     <= '0;
      frame_cnt    <= '0;
      req_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_calib_complete) state <= FILL;
        end
        FILL: begin
          if (fifo_rd_en) req_cnt <= req_cnt + 3'd1;
          if (word_full) begin
            state        <= ISSUE;
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
            req_cnt      <= '0;
          end
        end
        ISSUE: begin
          if (app_en && app_rdy)            app_en       <= 1'b0;
          if (app_wdf_wren && app_wdf_rdy)  app_wdf_wren <= 1'b0;
          if (accept) begin
            app_addr <= app_addr + ADDR_WIDTH'(WORD_ADDR_STEP);
            if (last_word) begin
              word_cnt <= '0;
              if (last_frame) begin
                state        <= DONE;
                end_of_write <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
                state     <= FILL;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= FILL;
            end
          end
        end
        DONE: begin
          end_of_write <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_word_packer.sv
// Directed bench for write_word_packer: 12-pixel frames, two frames, stalls, FIFO gaps and mid-word reset.
module tb_write_word_packer;

  localparam int unsigned AW = 27;
`ifdef WRITE_PACKER_MASK_EN
  localparam logic [15:0] FULL_MASK = 16'h8000;
  localparam logic [15:0] PART_MASK = 16'hFFC0;
`else
  localparam logic [15:0] FULL_MASK = 16'h0000;
  localparam logic [15:0] PART_MASK = 16'h0000;
`endif

  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_word_t;

  logic          clk = 1'b0;
  logic          cpu_resetn;
  logic          init_calib_complete;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [23:0]   fifo_dout;
  logic          fifo_valid;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [127:0]  app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic          end_of_write;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned delivered = 0;
  int unsigned cmd_cnt = 0;
  int unsigned dat_cnt = 0;
  logic        toggle_mode = 1'b0;
  logic        gate = 1'b0;
  logic        pend = 1'b0;

  logic [23:0]   fq[$];
  logic [AW-1:0] exp_addr_q[$];
  exp_word_t     exp_data_q[$];

  write_word_packer #(
    .FRAME_PIXELS (12),
    .NUM_FRAMES   (2),
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (27'd0)
  ) dut (
    .clk                 (clk),
    .cpu_resetn          (cpu_resetn),
    .init_calib_complete (init_calib_complete),
    .fifo_empty          (fifo_empty),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_dout           (fifo_dout),
    .fifo_valid          (fifo_valid),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .end_of_write        (end_of_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, ~b, b ^ 8'h5A};
  endfunction

  // FIFO model: data appears one cycle after a read request; empty can be forced low-duty.
  always @(negedge clk) begin
    if (!cpu_resetn) begin
      fifo_valid = 1'b0;
      pend       = 1'b0;
    end else begin
      fifo_valid = pend;
      if (pend) begin
        fifo_dout = fq.pop_front();
        delivered++;
      end
      gate       = toggle_mode ? ~gate : 1'b0;
      fifo_empty = (fq.size() == 0) || gate;
      #1;
      pend = fifo_rd_en;
      if (fifo_rd_en) chk("rd_while_empty", 128'(fifo_empty), 128'(0));
    end
  end

  // Scoreboard: each accepted command/data beat is compared against the queued expectation.
  always @(negedge clk) begin
    if (cpu_resetn) begin
      if (app_en && app_rdy) begin
        cmd_cnt++;
        if (exp_addr_q.size() == 0) chk("addr_extra", 128'(cmd_cnt), 128'(0));
        else begin
          chk("app_addr", 128'(app_addr), 128'(exp_addr_q.pop_front()));
          chk("app_cmd", 128'(app_cmd), 128'(3'b000));
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        exp_word_t e;
        dat_cnt++;
        if (exp_data_q.size() == 0) chk("data_extra", 128'(dat_cnt), 128'(0));
        else begin
          e = exp_data_q.pop_front();
          chk("wdf_data", app_wdf_data, e.data);
          chk("wdf_mask", 128'(app_wdf_mask), 128'(e.mask));
          chk("wdf_end", 128'(app_wdf_end), 128'(1));
          chk("eow_early", 128'(end_of_write), 128'(0));
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] held_addr;
    logic [127:0]  held_data;
    bit            hit;

    cpu_resetn = 1'b0;
    init_calib_complete = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    fifo_valid = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;

    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) begin
        exp_word_t e;
        e.data = '0;
        for (int s = 0; s < ((w == 2) ? 2 : 5); s++) e.data[24*s +: 24] = pix(f*12 + w*5 + s + 1);
        e.mask = (w == 2) ? PART_MASK : FULL_MASK;
        exp_data_q.push_back(e);
        exp_addr_q.push_back(AW'((f*3 + w) * 8));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 128'(app_en), 128'(0));
    chk("rst_wren", 128'(app_wdf_wren), 128'(0));
    chk("rst_rd", 128'(fifo_rd_en), 128'(0));
    chk("rst_eow", 128'(end_of_write), 128'(0));
    chk("rst_addr", 128'(app_addr), 128'(0));
    chk("rst_data", app_wdf_data, 128'(0));
    chk("rst_mask", 128'(app_wdf_mask), 128'(0));

    // Mid-word reset: three pixels captured, then reset must discard them.
    cpu_resetn = 1'b1;
    for (int i = 1; i <= 3; i++) fq.push_back(pix(100 + i));
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_rd", 128'(delivered), 128'(0));
    init_calib_complete = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      #1;
      hit = (delivered == 3);
    end
    chk("rst_test_delivered", 128'(delivered), 128'(3));
    @(posedge clk);
    #1;
    chk("partial_slots", 128'(app_wdf_data[71:0]), 128'({pix(103), pix(102), pix(101)}));
    chk("partial_no_issue", 128'(app_en), 128'(0));
    #2;
    cpu_resetn = 1'b0;
    #1;
    chk("mid_rst_data", app_wdf_data, 128'(0));
    chk("mid_rst_addr", 128'(app_addr), 128'(0));
    chk("mid_rst_strobes", 128'({fifo_rd_en, app_en, app_wdf_wren, end_of_write}), 128'(0));
    fq.delete();
    @(posedge clk);
    #1;
    cpu_resetn = 1'b1;

    // Two frames of 12 pixels, FIFO empty every other cycle, first command stalled.
    toggle_mode = 1'b1;
    app_rdy = 1'b0;
    for (int k = 1; k <= 24; k++) fq.push_back(pix(k));
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk);
      #1;
      hit = app_en;
    end
    chk("stall_en_seen", 128'(app_en), 128'(1));
    chk("stall_wren_with_en", 128'(app_wdf_wren), 128'(1));
    held_addr = app_addr;
    held_data = app_wdf_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_wren_low", 128'(app_wdf_wren), 128'(0));
      chk("stall_en_high", 128'(app_en), 128'(1));
      chk("stall_addr", 128'(app_addr), 128'(held_addr));
      chk("stall_data", app_wdf_data, held_data);
      chk("stall_no_rd", 128'(fifo_rd_en), 128'(0));
    end
    chk("stall_delivered", 128'(delivered), 128'(8));
    app_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_en", 128'(app_en), 128'(0));

    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(posedge clk);
      #1;
      hit = end_of_write;
    end
    chk("eow_set", 128'(end_of_write), 128'(1));
    chk("cmd_count", 128'(cmd_cnt), 128'(6));
    chk("data_count", 128'(dat_cnt), 128'(6));
    chk("pixel_count", 128'(delivered), 128'(27));
    chk("addr_q_drained", 128'(exp_addr_q.size()), 128'(0));
    chk("final_addr", 128'(app_addr), 128'(48));

    // DONE holds: extra pixels must not be read and nothing is issued.
    fq.push_back(pix(200));
    fq.push_back(pix(201));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("done_quiet", 128'({fifo_rd_en, app_en, app_wdf_wren, end_of_write}), 128'(1));
    end
    chk("done_fifo_untouched", 128'(fq.size()), 128'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
